// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions used by the arbiter, Processor12 and the DMA engine.
// Holds the address/data widths, the arbiter lock-state type and a one-hot to
// index helper.
package mem_bus_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } lock_state_e;

  // Index of the set bit in a one-hot (or zero) vector; zero input gives 0.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting one position after ptr, wrapping modulo N.
// Ports:
//   req        in  N   request vector
//   ptr        in  PW  index of the last winner
//   gnt_onehot out N   one-hot winner (zero if no request)
//   gnt_idx    out PW  index of the winner (0 if no request)
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx
);

  localparam logic [PW:0] NumW = (PW+1)'(N);

  logic [PW:0] cand;
  logic        found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= int'(N); k++) begin
      // Explicit modulo wrap so non-power-of-two N works.
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= NumW) cand = cand - NumW;
      if (!found && req[cand[PW-1:0]]) begin
        found                      = 1'b1;
        gnt_onehot[cand[PW-1:0]]   = 1'b1;
        gnt_idx                    = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NUM_REQ masters,
// with an optional bounded bus lock for atomic read-modify-write or short bursts.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req/lock/we       per-master request, lock-hold and write-enable
//   addr/wdata        packed per-master address and write data
//   gnt               one-hot (or zero) grant
//   rvalid            per-master read data valid, one cycle after a read grant
//   rdata             shared read data (mem_q)
//   mem_*             RAM interface; all zero when nothing is granted
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         mem_q
);

  localparam int unsigned PW       = $clog2(NUM_REQ);
  localparam logic [3:0]  LockLast = 4'(LOCK_MAX - 1);

  lock_state_e          state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        lock_owner_q, lock_owner_d;
  logic [3:0]           lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        pick_idx;
  logic [MAX_REQ-1:0]   gnt_ext;
  logic [PW-1:0]        g_idx;
  logic                 gnt_any;
  logic                 lock_ok;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx)
  );

  // Grant: lock owner keeps the bus only while it still requests; otherwise
  // fall through to round-robin in the same cycle.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state_q == StLocked && req[lock_owner_q]) gnt[lock_owner_q] = 1'b1;
      else                                          gnt = pick_onehot;
    end
    gnt_any                = |gnt;
    gnt_ext                = '0;
    gnt_ext[NUM_REQ-1:0]   = gnt;
    g_idx                  = PW'(onehot_to_idx(gnt_ext));
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        mem_address = addr[ADDR_W*i +: ADDR_W];
        mem_data    = wdata[DATA_W*i +: DATA_W];
        mem_write   = we[i];
        mem_read    = ~we[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    lock_ok      = lock[g_idx] && (state_q == StUnlocked || lock_owner_q == g_idx) &&
                   (lock_cnt_q < LockLast);
    if (gnt_any) begin
      ptr_d = g_idx;
      if (lock_ok) begin
        state_d      = StLocked;
        lock_owner_d = g_idx;
        lock_cnt_d   = lock_cnt_q + 4'd1;
      end else begin
        // Release after LOCK_MAX grants; ptr=g makes the owner lowest priority.
        state_d    = StUnlocked;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = StUnlocked;
      lock_cnt_d = '0;
    end
    rvalid_d = gnt & ~we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StUnlocked;
      ptr_q        <= PW'(NUM_REQ - 1);
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = mem_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a small 1-cycle RAM model.
module tb_mem_bus_arbiter;

  localparam int unsigned N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lock, we, gnt, rvalid;
  logic [N*24-1:0] addr;
  logic [N*12-1:0] wdata;
  logic [11:0]   rdata, mem_data, mem_q;
  logic [23:0]   mem_address;
  logic          mem_read, mem_write;

  logic [11:0]   ram [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_REQ  (N),
    .LOCK_MAX (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_data    (mem_data),
    .mem_q       (mem_q)
  );

  // Synchronous RAM, registered read data.
  always @(posedge clk) begin
    if (mem_write) ram[mem_address[7:0]] <= mem_data;
    mem_q <= ram[mem_address[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] exp_g;

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 12'(a);
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

    // Reset state: outputs forced quiet even with requests present.
    req = 3'b111;
    for (int i = 0; i < 3; i++) addr[24*i +: 24] = 24'(16 + i);
    tick();
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_address), 32'd0);
    tick();
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);

    // 1: round-robin fairness with reads, rvalid/rdata one cycle later.
    do_reset();
    req = 3'b111; lock = '0; we = '0;
    for (int k = 0; k < 4; k++) begin
      exp_g = 3'b001 << (k % 3);
      #1;
      check_eq("rr_gnt", 32'(gnt), 32'(exp_g));
      check_eq("rr_mem_read", 32'(mem_read), 32'd1);
      check_eq("rr_mem_addr", 32'(mem_address), 32'(16 + k % 3));
      tick();
      check_eq("rr_rvalid", 32'(rvalid), 32'(exp_g));
      check_eq("rr_rdata", 32'(rdata), 32'(16 + k % 3));
    end

    // 2: master 1 writes, then master 0 reads back.
    do_reset();
    req = 3'b010; we = 3'b010; lock = '0;
    addr[24 +: 24] = 24'o00000100; wdata[12 +: 12] = 12'o1234;
    #1;
    check_eq("wr_gnt", 32'(gnt), 32'b010);
    check_eq("wr_mem_write", 32'(mem_write), 32'd1);
    check_eq("wr_mem_addr", 32'(mem_address), 32'o100);
    check_eq("wr_mem_data", 32'(mem_data), 32'o1234);
    tick();
    check_eq("wr_no_rvalid", 32'(rvalid), 32'd0);
    req = 3'b001; we = 3'b000; addr[0 +: 24] = 24'o00000100;
    #1;
    check_eq("rd_gnt", 32'(gnt), 32'b001);
    tick();
    req = 3'b000;
    check_eq("rd_rvalid", 32'(rvalid), 32'b001);
    check_eq("rd_rdata", 32'(rdata), 32'o1234);

    // 3: master 2 lock bounded at 4 grants, then round-robin resumes.
    do_reset();
    we = '0; lock = 3'b100; req = 3'b100;
    #1;
    check_eq("lk_first", 32'(gnt), 32'b100);
    tick();
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0, 1, 2: exp_g = 3'b100;
        3:       exp_g = 3'b001;
        4:       exp_g = 3'b010;
        default: exp_g = 3'b100;
      endcase
      #1;
      check_eq("lk_seq", 32'(gnt), 32'(exp_g));
      tick();
    end

    // 4: lock owner drops req; master 0 wins in the same cycle.
    do_reset();
    lock = 3'b010; req = 3'b010;
    #1;
    check_eq("drop_lock_gnt", 32'(gnt), 32'b010);
    tick();
    lock = '0; req = 3'b001;
    #1;
    check_eq("drop_no_bubble", 32'(gnt), 32'b001);
    tick();
    req = 3'b110;
    #1;
    check_eq("drop_after", 32'(gnt), 32'b010);
    tick();

    // 5: reset right after a read grant kills the pending rvalid.
    do_reset();
    req = 3'b001; we = '0; addr[0 +: 24] = 24'd5;
    #1;
    check_eq("mr_gnt", 32'(gnt), 32'b001);
    rst = 1'b1;
    tick();
    check_eq("mr_rvalid", 32'(rvalid), 32'd0);
    check_eq("mr_gnt_rst", 32'(gnt), 32'd0);
    check_eq("mr_mem_read", 32'(mem_read), 32'd0);
    check_eq("mr_mem_addr", 32'(mem_address), 32'd0);
    rst = 1'b0;

    // 6: idle cycles preserve ptr.
    do_reset();
    req = 3'b001;
    #1;
    check_eq("idle_pre", 32'(gnt), 32'b001);
    tick();
    req = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("idle_gnt", 32'(gnt), 32'd0);
      check_eq("idle_mem", 32'({mem_read, mem_write, mem_address}), 32'd0);
      tick();
    end
    req = 3'b011;
    #1;
    check_eq("idle_resume1", 32'(gnt), 32'b010);
    tick();
    #1;
    check_eq("idle_resume2", 32'(gnt), 32'b001);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
